// File: rtl/lin_pkg.sv
// Shared LIN definitions: UART-framed symbol constants, header FSM encoding
// and the protected-identifier parity helper.
package lin_pkg;

    localparam logic [9:0] LIN_SYM_IDLE  = 10'h3FF;
    localparam logic [9:0] LIN_SYM_SYNC  = 10'h2AA;
    localparam logic [9:0] LIN_SYM_BRK   = 10'h000;
    localparam logic [9:0] LIN_SYM_DELIM = 10'h200;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_BREAK = 3'd1,
        ST_SYNC  = 3'd2,
        ST_PID   = 3'd3,
        ST_WAIT  = 3'd4
    } lin_state_e;

    // Returns {P1, P0} for a 6-bit frame identifier.
    function automatic logic [1:0] lin_pid_parity(input logic [5:0] id);
        logic p0;
        logic p1;
        p0 = id[0] ^ id[1] ^ id[2] ^ id[4];
        p1 = ~(id[1] ^ id[3] ^ id[4] ^ id[5]);
        return {p1, p0};
    endfunction

endpackage

// File: rtl/lin_tbl_arbiter.sv
// Priority encoder over the schedule-table enables: the highest set bit wins.
module lin_tbl_arbiter #(
    parameter int NUM_TABLES = 3,
    parameter int TW         = 2
) (
    input  logic [NUM_TABLES-1:0] tbl_en,
    output logic [TW-1:0]         act_idx,
    output logic                  any_en
);

    always_comb begin
        act_idx = '0;
        for (int i = 0; i < NUM_TABLES; i++) begin
            if (tbl_en[i]) act_idx = TW'(i);
        end
    end

    assign any_en = |tbl_en;

endmodule

// File: rtl/lin_header_gen.sv
// LIN master header generator: break symbols, SYNC and PID, one 10-bit framed
// symbol per clock, inside a fixed-length slot with table-change abort.
module lin_header_gen #(
    parameter int  BRK_SYMS    = 2,
    parameter int  SLOT_CYCLES = 15,
    parameter int  NUM_TABLES  = 3,
    localparam int TW          = (NUM_TABLES > 1) ? $clog2(NUM_TABLES) : 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NUM_TABLES-1:0] tbl_en,
    input  logic                  id_valid,
    input  logic [5:0]            id_in,
    output logic                  id_ready,
    output logic [9:0]            sym_out,
    output logic                  sym_valid,
    output logic [TW-1:0]         hdr_tbl,
    output logic                  hdr_done,
    output logic                  slot_end,
    output logic                  abort,
    output logic [2:0]            dbg_state
);
    import lin_pkg::*;

    localparam int CW = (SLOT_CYCLES > 1) ? $clog2(SLOT_CYCLES) : 1;
    localparam int BW = $clog2(BRK_SYMS);

    lin_state_e    state, state_n;
    logic [BW-1:0] brk_idx, brk_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [5:0]    id_reg, id_n;
    logic [9:0]    sym_n;
    logic          symv_n, done_n, abort_n;
    logic [TW-1:0] tbl_n;
    logic [TW-1:0] act_idx;
    logic          any_en, cur_en, cnt_end, abort_cond, accept;

    lin_tbl_arbiter #(.NUM_TABLES(NUM_TABLES), .TW(TW)) u_arb (
        .tbl_en  (tbl_en),
        .act_idx (act_idx),
        .any_en  (any_en)
    );

    // Enable bit of the table the running header was accepted under.
    always_comb begin
        cur_en = 1'b0;
        for (int i = 0; i < NUM_TABLES; i++) begin
            if (hdr_tbl == TW'(i)) cur_en = tbl_en[i];
        end
    end

    // Handshake: id_in is taken on any cycle where id_valid && id_ready; id_ready
    // never depends on id_valid and the sequencer must hold id_in while id_valid waits.
    assign cnt_end    = (cnt == CW'(SLOT_CYCLES - 1));
    assign abort_cond = (state != ST_IDLE) && (!cur_en || (act_idx > hdr_tbl));
    assign id_ready   = !reset && any_en && !abort_cond &&
                        ((state == ST_IDLE) || ((state == ST_WAIT) && cnt_end));
    assign slot_end   = !reset && (state == ST_WAIT) && cnt_end && !abort_cond;
    assign accept     = id_valid && id_ready;
    assign dbg_state  = state;

    always_comb begin
        state_n = state;
        brk_n   = brk_idx;
        cnt_n   = cnt;
        id_n    = id_reg;
        tbl_n   = hdr_tbl;
        sym_n   = sym_out;
        symv_n  = sym_valid;
        done_n  = 1'b0;
        abort_n = 1'b0;
        if (abort_cond) begin
            state_n = ST_IDLE;
            cnt_n   = '0;
            sym_n   = LIN_SYM_IDLE;
            symv_n  = 1'b0;
            abort_n = 1'b1;
        end else if (accept) begin
            state_n = ST_BREAK;
            brk_n   = '0;
            cnt_n   = '0;
            id_n    = id_in;
            tbl_n   = act_idx;
            sym_n   = LIN_SYM_BRK;
            symv_n  = 1'b1;
        end else begin
            case (state)
                ST_BREAK: begin
                    cnt_n = cnt + CW'(1);
                    if (brk_idx == BW'(BRK_SYMS - 1)) begin
                        state_n = ST_SYNC;
                        sym_n   = LIN_SYM_SYNC;
                    end else begin
                        brk_n = brk_idx + BW'(1);
                        sym_n = (brk_idx == BW'(BRK_SYMS - 2)) ? LIN_SYM_DELIM : LIN_SYM_BRK;
                    end
                end
                ST_SYNC: begin
                    cnt_n   = cnt + CW'(1);
                    state_n = ST_PID;
                    sym_n   = {1'b1, lin_pid_parity(id_reg), id_reg, 1'b0};
                end
                ST_PID: begin
                    cnt_n   = cnt + CW'(1);
                    state_n = ST_WAIT;
                    sym_n   = LIN_SYM_IDLE;
                    symv_n  = 1'b0;
                    done_n  = 1'b1;
                end
                ST_WAIT: begin
                    // Counter holds at the slot end rather than wrapping.
                    if (cnt_end) state_n = ST_IDLE;
                    else         cnt_n   = cnt + CW'(1);
                end
                default: begin
                    state_n = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_IDLE;
            brk_idx   <= '0;
            cnt       <= '0;
            id_reg    <= '0;
            hdr_tbl   <= '0;
            sym_out   <= LIN_SYM_IDLE;
            sym_valid <= 1'b0;
            hdr_done  <= 1'b0;
            abort     <= 1'b0;
        end else begin
            state     <= state_n;
            brk_idx   <= brk_n;
            cnt       <= cnt_n;
            id_reg    <= id_n;
            hdr_tbl   <= tbl_n;
            sym_out   <= sym_n;
            sym_valid <= symv_n;
            hdr_done  <= done_n;
            abort     <= abort_n;
        end
    end

endmodule
